// File: rtl/dir_lut_pkg.sv
// dir_lut_pkg: shared widths, bin type and wrap-around helper for the
// direction-bin lookup pipeline.
//   DIR_ADDR_W   default lookup address width (table depth 2**DIR_ADDR_W)
//   DIR_DATA_W   default orientation bin width (bins wrap mod 2**DIR_DATA_W)
//   dir_bin_t    one orientation bin code
//   dir_wrap_sub (a - b) mod 2**DIR_DATA_W
package dir_lut_pkg;

    localparam int DIR_ADDR_W = 8;
    localparam int DIR_DATA_W = 5;

    typedef logic [DIR_DATA_W-1:0] dir_bin_t;

    // Unsigned subtraction truncated to the bin width is exactly the modulo wrap.
    function automatic dir_bin_t dir_wrap_sub(input dir_bin_t a, input dir_bin_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/dir_lut_pipe_if.sv
// dir_lut_pipe_if: stream, table-write and status signals of dir_lut_pipe.
//   in_valid/in_ready/in_addr      input beat handshake, LANES packed addresses
//   wr_en/wr_addr/wr_data          table write port (all lane copies)
//   rot                            per-beat rotation (only with DIR_LUT_ROT_EN)
//   out_valid/out_ready/out_dir    output beat handshake, LANES packed bins
//   beat_cnt                       count of transferred output beats
// modport master: the side that feeds beats and consumes results.
// modport slave:  the lookup pipeline itself.
// Build option: DIR_LUT_ROT_EN adds the rot signal.
interface dir_lut_pipe_if
    import dir_lut_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = DIR_ADDR_W,
    parameter int DATA_W = DIR_DATA_W,
    parameter int CNT_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*ADDR_W-1:0] in_addr;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
`ifdef DIR_LUT_ROT_EN
    logic [DATA_W-1:0]       rot;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_dir;
    logic [CNT_W-1:0]        beat_cnt;

`ifdef DIR_LUT_ROT_EN
    modport master (
        output in_valid, in_addr, wr_en, wr_addr, wr_data, rot, out_ready,
        input  in_ready, out_valid, out_dir, beat_cnt
    );
    modport slave (
        input  in_valid, in_addr, wr_en, wr_addr, wr_data, rot, out_ready,
        output in_ready, out_valid, out_dir, beat_cnt
    );
`else
    modport master (
        output in_valid, in_addr, wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_dir, beat_cnt
    );
    modport slave (
        input  in_valid, in_addr, wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_dir, beat_cnt
    );
`endif

endinterface

// File: rtl/dir_lut_mem.sv
// dir_lut_mem: one lane's 2**ADDR_W x DATA_W direction table.
//   clk, rst_n        clock, async active-low reset (read register only)
//   wr_en/addr/data   synchronous write port
//   rd_en, rd_addr    registered read, captured when rd_en=1
//   rd_data           read register; holds while rd_en=0
// A same-edge read and write of one address returns the old contents:
// both are non-blocking updates on the same edge, so the read samples the
// array before the write lands. The array itself is never reset so a table
// survives a pipeline reset.
module dir_lut_mem
    import dir_lut_pkg::*;
#(
    parameter int ADDR_W = DIR_ADDR_W,
    parameter int DATA_W = DIR_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dir_lut_pipe.sv
// dir_lut_pipe: two-stage, reloadable gradient-code -> orientation-bin lookup
// on LANES parallel lanes with valid/ready flow control.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dir_lut_pipe_if.slave (beats in, table writes, beats out, beat_cnt)
// Stage 1 registers the lane addresses (and rotation); stage 2 is the lane
// tables' read registers. Both stages advance together whenever the output
// register is empty or being taken, so a stall freezes the whole pipe and
// out_dir stays stable.
// Build option: DIR_LUT_ROT_EN subtracts the per-beat rotation from every
// lane's bin (mod 2**DATA_W); otherwise out_dir is the raw table contents.
module dir_lut_pipe
    import dir_lut_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = DIR_ADDR_W,
    parameter int DATA_W = DIR_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    dir_lut_pipe_if.slave bus
);

    logic                    adv;
    logic                    s1_valid;
    logic [LANES*ADDR_W-1:0] s1_addr;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [LANES*DATA_W-1:0] dir_comb;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_dir  = dir_comb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            bus.out_valid <= 1'b0;
            bus.beat_cnt  <= '0;
        end else begin
            if (adv) begin
                s1_valid      <= bus.in_valid;
                s1_addr       <= bus.in_addr;
                bus.out_valid <= s1_valid;
            end
            if (bus.out_valid && bus.out_ready) begin
                bus.beat_cnt <= bus.beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DIR_LUT_ROT_EN
    // Rotation travels alongside its beat so it lines up with the read data.
    logic [DATA_W-1:0] s1_rot;
    logic [DATA_W-1:0] s2_rot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rot <= '0;
            s2_rot <= '0;
        end else if (adv) begin
            s1_rot <= bus.rot;
            s2_rot <= s1_rot;
        end
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dir_lut_mem #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_mem (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_en   (adv),
            .rd_addr (s1_addr[i*ADDR_W +: ADDR_W]),
            .rd_data (rd_data[i*DATA_W +: DATA_W])
        );

`ifdef DIR_LUT_ROT_EN
        if (DATA_W == DIR_DATA_W) begin : g_pkg_sub
            assign dir_comb[i*DATA_W +: DATA_W] =
                dir_wrap_sub(rd_data[i*DATA_W +: DATA_W], s2_rot);
        end else begin : g_gen_sub
            // Same wrap at a non-default bin width.
            assign dir_comb[i*DATA_W +: DATA_W] = rd_data[i*DATA_W +: DATA_W] - s2_rot;
        end
`else
        assign dir_comb[i*DATA_W +: DATA_W] = rd_data[i*DATA_W +: DATA_W];
`endif
    end

endmodule
